// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front-end frame sequencer.
// Holds the state encoding, complex width derivation and conj-saturate helper.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2
  } seq_state_e;

  function automatic int cplx_width(input int rw, input int iw);
    return rw + iw;
  endfunction

  // Negate a w-bit two's complement value held in the low bits of v.
  // The most negative code has no positive twin, so it clamps to max.
  function automatic logic [63:0] conj_sat(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] mask;
    logic [63:0] minv;
    logic [63:0] vm;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    vm   = v & mask;
    if (vm == minv)
      return minv - 64'd1;
    else
      return (~vm + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/fft_seq_addr_cnt.sv
// In-frame address counter: holds the index of the next emitted beat.
// Ports: iclk, rst (sync), clr, inc -> cnt (next address), tc (cnt is N-1).
module fft_seq_addr_cnt #(
  parameter int W = 11
) (
  input  logic         iclk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge iclk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  assign tc = &cnt;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Front-end frame sequencer feeding the first butterfly stage.
// Ports: iclk, rst, ivalid/iready/idata/ilast, iabort in; oen/oaddr/odata,
// ostart/odone/oabort, obusy, oframe_cnt out. Optional imode with
// FFT_SEQ_CONJ_EN (imaginary negate with saturation for IFFT).
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int REAL_WIDTH  = 18,
  parameter int IMGN_WIDTH  = 18,
  parameter int TOTAL_STAGE = 11,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                                iclk,
  input  logic                                rst,
  input  logic                                ivalid,
  output logic                                iready,
  input  logic [REAL_WIDTH+IMGN_WIDTH-1:0]    idata,
  input  logic                                ilast,
  input  logic                                iabort,
`ifdef FFT_SEQ_CONJ_EN
  input  logic                                imode,
`endif
  output logic                                oen,
  output logic [TOTAL_STAGE-1:0]              oaddr,
  output logic [REAL_WIDTH+IMGN_WIDTH-1:0]    odata,
  output logic                                ostart,
  output logic                                odone,
  output logic                                oabort,
  output logic                                obusy,
  output logic [FRAME_CNT_W-1:0]              oframe_cnt
);

  localparam int CW = cplx_width(REAL_WIDTH, IMGN_WIDTH);

  seq_state_e             state;
  logic                   accept;
  logic                   cnt_inc;
  logic [TOTAL_STAGE-1:0] cnt;
  logic                   tc;
  logic [CW-1:0]          data_in;

  assign iready  = (state != ST_PAD) & ~iabort & ~rst;
  assign accept  = ivalid & iready;
  assign cnt_inc = ~iabort & (accept | (state == ST_PAD));
  assign obusy   = (state != ST_IDLE);

`ifdef FFT_SEQ_CONJ_EN
  logic [IMGN_WIDTH-1:0] im_neg;
  assign im_neg = IMGN_WIDTH'(conj_sat(64'(idata[IMGN_WIDTH-1:0]),
                                       IMGN_WIDTH));
  assign data_in = imode ? {idata[CW-1:IMGN_WIDTH], im_neg} : idata;
`else
  assign data_in = idata;
`endif

  fft_seq_addr_cnt #(
    .W (TOTAL_STAGE)
  ) u_cnt (
    .iclk (iclk),
    .rst  (rst),
    .clr  (iabort),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_ff @(posedge iclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      oen        <= 1'b0;
      oaddr      <= '1;
      odata      <= '0;
      ostart     <= 1'b0;
      odone      <= 1'b0;
      oabort     <= 1'b0;
      oframe_cnt <= '0;
    end else if (iabort) begin
      state  <= ST_IDLE;
      oen    <= 1'b0;
      oaddr  <= '1;
      odata  <= '0;
      ostart <= 1'b0;
      odone  <= 1'b0;
      oabort <= (state != ST_IDLE);
    end else begin
      oen    <= 1'b0;
      oaddr  <= '1;
      odata  <= '0;
      ostart <= 1'b0;
      odone  <= 1'b0;
      oabort <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            oen    <= 1'b1;
            oaddr  <= cnt;
            odata  <= data_in;
            ostart <= 1'b1;
            state  <= ilast ? ST_PAD : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            oen    <= 1'b1;
            oaddr  <= cnt;
            odata  <= data_in;
            ostart <= (cnt == '0);
            if (tc) begin
              odone      <= 1'b1;
              oframe_cnt <= oframe_cnt + 1'b1;
              state      <= ilast ? ST_IDLE : ST_RUN;
            end else if (ilast) begin
              state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          oen   <= 1'b1;
          oaddr <= cnt;
          if (tc) begin
            odone      <= 1'b1;
            oframe_cnt <= oframe_cnt + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Front-end controller for the flow FFT/IFFT pipeline. Accepts a valid/ready complex sample stream and drives the first butterfly stage's ien/iaddr/idata interface with frame-aligned addresses. Completes partial frames with zero padding, supports abort, and reports frame start/done and a frame count. Sits between the sample source and the first BF stage of the chain.

Parameters:
REAL_WIDTH, 18, real-part width (two's complement)
IMGN_WIDTH, 18, imaginary-part width (two's complement)
TOTAL_STAGE, 11, log2 of FFT length N; width of oaddr
FRAME_CNT_W, 16, width of frame counter

Ports:
iclk  in  1  clock
rst  in  1  synchronous reset, active-high
ivalid  in  1  input sample valid
iready  out  1  sequencer can accept sample (combinational)
idata  in  REAL_WIDTH+IMGN_WIDTH  sample {real, imag}
ilast  in  1  last sample of stream/burst; qualified by ivalid&iready
iabort  in  1  drop current frame, return to idle
oen  out  1  sample enable to first BF stage
oaddr  out  TOTAL_STAGE  in-frame sample index
odata  out  REAL_WIDTH+IMGN_WIDTH  sample to first BF stage
ostart  out  1  pulse with the oaddr==0 beat
odone  out  1  pulse with the oaddr==N-1 beat
oabort  out  1  one-cycle pulse after an abort of a partial frame
obusy  out  1  high while in RUN or PAD
oframe_cnt  out  FRAME_CNT_W  completed frames, wraps

Behaviour:
- Clock iclk, one domain; rst synchronous active-high. Reset: oen=0, oaddr=all-ones, odata=0, ostart=odone=oabort=0, oframe_cnt=0, state IDLE.
- All outputs except iready registered; accepted beat at cycle t appears on oen/oaddr/odata at t+1. No downstream backpressure.
- iready = (state!=PAD) & ~iabort & ~rst.
- States:
  - IDLE: next address 0. Accept -> emit addr 0, ostart=1, go RUN. If ilast also set, go PAD (N>1).
  - RUN: each accept emits addr+1. At addr N-1: odone=1, oframe_cnt+1, next address 0. Next state IDLE if ilast, else stays RUN. No accept -> oen=0, oaddr=all-ones, odata=0, counter holds (gaps allowed).
  - RUN with ilast at addr != N-1: go PAD.
  - PAD: emit odata=0, oen=1 every cycle, consecutive addresses through N-1 inclusive; odone and oframe_cnt increment on the N-1 beat; then IDLE.
- Since idle-beat oaddr is all-ones, the all-ones address is meaningful only when oen=1.
- iabort (any state): next cycle oen=0, oaddr=all-ones, address counter reset, state IDLE. oabort=1 only if aborting mid-frame (RUN or PAD). oframe_cnt unchanged. Abort beats a simultaneous ivalid: sample not accepted.
- Reset during RUN/PAD: identical to power-on reset; no oabort.
- N-1 beat with ilast: odone, no PAD.
- oframe_cnt wraps from all-ones to 0.

Optional Feature:
FFT_SEQ_CONJ_EN: adds input port imode (1 bit, sampled per accepted beat). When imode=1, the imaginary part is negated for IFFT-by-conjugation; -2^(IMGN_WIDTH-1) saturates to 2^(IMGN_WIDTH-1)-1. PAD zeros are unaffected. Without the macro, there is no imode port and data passes unmodified.

Decomposition:
- Shared package fft_pkg: state encoding (IDLE/RUN/PAD), CPLX_WIDTH derivation, and a conj-saturate function.
- One sub-module, fft_seq_addr_cnt: address counter with clear, increment, and terminal-count flag.

Test Plan:
- N=16 (TOTAL_STAGE=4), 32 back-to-back samples, ilast on 32nd -> oaddr 0..15 twice with no gaps; ostart at beats 1 and 17; odone at beats 16 and 32; oframe_cnt=2; iready never low.
- N=16, 5 samples, ilast on 5th -> addr 0..4 carry data, addr 5..15 carry zero with oen=1, iready=0 for 11 cycles, odone on addr 15, oframe_cnt=1.
- N=16, ivalid toggling 1/0 -> oen tracks accepts with 1-cycle latency; oaddr=all-ones on gap cycles; addresses contiguous across gaps.
- Abort with ivalid asserted at addr 7 -> no accept that cycle; next cycle oen=0, oabort=1; oframe_cnt unchanged; next sample emitted at addr 0 with ostart.
- Reset asserted during PAD -> next cycle all outputs at reset values, oabort=0, iready=1 after rst deasserts.
- FFT_SEQ_CONJ_EN, imode=1, input imag=-131072 (width 18) -> output imag=131071; imag=5 -> -5; real unchanged.
